fp_addsub_issue: RTL and testbench
==================================

Name: fp_addsub_issue

Overview:
Registered issue/capture stage wrapped around the existing combinational single-precision add/sub datapath.
- Accepts operand pairs over a valid/ready handshake and registers them.
- Drives the adder's A/B/O/Cin inputs from that register.
- Captures the adder's Fout one cycle later.
- Overrides the captured result for IEEE special cases the datapath does not handle: NaN, infinity, zero/denormal, and exact cancellation.
- Presents the result downstream with valid/ready backpressure.

Parameters:
QNAN, 32'h7FC0_0000, canonical quiet NaN returned for invalid cases.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  stage can accept the operand pair this cycle
in_op  input  1  0 = A+B, 1 = A-B
in_a  input  32  IEEE-754 single operand A
in_b  input  32  IEEE-754 single operand B
add_o  output  1  to adder O
add_a  output  32  to adder A
add_b  output  32  to adder B
add_cin  output  1  to adder Cin, constant 0
add_fout  input  32  from adder Fout, combinational in add_a/add_b/add_o
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_result  output  32  final IEEE-754 result
out_flags  output  3  [2] nan, [1] inf, [0] zero
op_count  output  CNT_W  count of results accepted downstream

Behaviour:
- Reset (async assert, sync release): S1 valid = 0, S2 valid = 0, out_valid = 0, out_result = 0, out_flags = 0, op_count = 0, add_a = 0, add_b = 0, add_o = 0. in_ready = 1 immediately after reset.
- Pipeline: S1 is the operand register and drives add_*. S2 is the output register.
- Handshake and latency:
  - Transfer occurs when valid && ready.
  - Latency is 2 cycles: in transfer at edge N → out_valid = 1 after edge N+1.
  - Throughput is 1 per cycle when out_ready = 1.
- Enables and in_ready:
  - s2_en = !out_valid || out_ready.
  - S1 → S2 moves when S1 valid && s2_en.
  - in_ready = !s1_valid || s2_en (pass-through ready, no skid).
  - Full stall: in_ready = 0 exactly when both S1 and S2 are valid and out_ready = 0.
- Output stability: out_result and out_flags hold stable while out_valid && !out_ready.
- Operand classification (per operand, registered in S1 alongside the operands):
  - NaN: exp = FF and mantissa ≠ 0.
  - Inf: exp = FF and mantissa = 0.
  - Zero: exp = 00 (denormals flush to zero).
- Effective sign of B: sb' = b[31] ^ op.
- Override priority at S2 capture (first match wins):
  1. Either operand NaN → QNAN, flags 100.
  2. Both Inf and a[31] ≠ sb' → QNAN, flags 100.
  3. A Inf → {a[31], 8'hFF, 23'h0}, flags 010.
  4. B Inf → {sb', 8'hFF, 23'h0}, flags 010.
  5. Both Zero → {a[31] & sb', 31'h0}, flags 001.
  6. A Zero → {sb', b[30:0]}; flags 000, or 001 if B is also zero (already covered by case 5).
  7. B Zero → a, flags 000.
  8. a[30:0] == b[30:0] and a[31] ≠ sb' → 32'h0, flags 001.
  9. Otherwise → add_fout, flags 000. Result exp = FF sets inf flag 010; exp = 00 sets zero flag 001.
- Counter: op_count increments on each out_valid && out_ready and wraps modulo 2^CNT_W.
- Simultaneous events:
  - In-accept and out-accept in the same cycle both take effect; no bubble.
  - S1 load and S1 → S2 move in the same cycle: S2 takes the old S1, S1 takes the new operands.
- add_* hold their last value when S1 is empty; the captured value is only used when S1 is valid.
- Mid-operation reset: in-flight operations are discarded and no output is produced for them. op_count clears.

Decomposition:
- Package fp_pkg:
  - Constants EXP_MAX = 8'hFF and QNAN default.
  - Flag index localparams F_NAN = 2, F_INF = 1, F_ZERO = 0.
  - Struct fp_class_t {nan, inf, zero, sign}.
- One sub-module, fp_classify: combinational, 32-bit in → fp_class_t. Instantiated twice, for A and B.
- Override priority logic and pipeline control stay in fp_addsub_issue.

Test Plan:
- Normal add, real adder attached: in_a = 3F800000, in_b = 40000000, op = 0, out_ready = 1 → out_result = 40400000, flags 000, out_valid exactly 2 cycles after accept; op_count = 1.
- Inf − Inf: in_a = 7F800000, in_b = 7F800000, op = 1 → 7FC00000, flags 100. Inf + (−Inf) gives the same result. Inf + 1.0 → 7F800000, flags 010.
- Cancellation and zeros: 40400000 − 40400000 → 00000000, flags 001. (−0) + (−0) = 80000000 + 80000000 → 80000000, flags 001. 0 − 3F800000 → BF800000, flags 000.
- Backpressure: issue 3 back-to-back ops with out_ready = 0 for 5 cycles → in_ready falls after 2 accepted. The third is held at the input, out_result stays stable, then results drain in order when out_ready = 1. op_count = 3.
- Streaming: out_ready = 1, 8 consecutive valid inputs → 8 consecutive valid outputs, no bubbles, correct order.
- Reset mid-operation: assert rst_n = 0 with S1 and S2 full → out_valid = 0, op_count = 0 asynchronously. After release, in_ready = 1 and no stale result appears.

Source files
------------

// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
// Shared constants and types for the single-precision add/sub issue stage.
//   EXP_MAX      : all-ones biased exponent (Inf/NaN encodings)
//   QNAN_DEFAULT : canonical quiet NaN returned for invalid operations
//   F_NAN/F_INF/F_ZERO : bit positions inside the 3-bit result flag vector
//   fp_class_t   : per-operand classification carried alongside the operand
// ----------------------------------------------------------------------------
package fp_pkg;

    localparam logic [7:0]  EXP_MAX      = 8'hFF;
    localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;

    localparam int F_NAN  = 2;
    localparam int F_INF  = 1;
    localparam int F_ZERO = 0;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic sign;
    } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// ----------------------------------------------------------------------------
// fp_classify
// Combinational classification of one IEEE-754 single-precision value.
//   value : 32-bit operand
//   cls   : {nan, inf, zero, sign}; denormals are reported as zero
// ----------------------------------------------------------------------------
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] value,
    output fp_class_t   cls
);

    logic [7:0]  exp_field;
    logic [22:0] man_field;

    assign exp_field = value[30:23];
    assign man_field = value[22:0];

    always_comb begin
        cls      = '0;
        cls.nan  = (exp_field == EXP_MAX) && (man_field != 23'h0);
        cls.inf  = (exp_field == EXP_MAX) && (man_field == 23'h0);
        // Denormals flush to zero, so only the exponent matters here.
        cls.zero = (exp_field == 8'h00);
        cls.sign = value[31];
    end

endmodule

// File: rtl/fp_addsub_issue.sv
// ----------------------------------------------------------------------------
// fp_addsub_issue
// Two-register issue/capture stage around an external combinational
// single-precision adder. S1 holds the operand pair (and its classification)
// and drives the adder; S2 captures the adder output, replaced by the IEEE
// special-case result where the datapath cannot produce it.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready       : operand handshake
//   in_op                   : 0 = A+B, 1 = A-B
//   in_a, in_b              : operands
//   add_a/add_b/add_o/add_cin : to adder (add_cin tied 0)
//   add_fout                : from adder, combinational in add_a/add_b/add_o
//   out_valid/out_ready     : result handshake
//   out_result, out_flags   : result and {nan, inf, zero}
//   op_count                : results accepted downstream (wraps)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready does not depend on in_valid; out_result/out_flags hold while
// out_valid && !out_ready.
// ----------------------------------------------------------------------------
module fp_addsub_issue
    import fp_pkg::*;
#(
    parameter logic [31:0] QNAN  = QNAN_DEFAULT,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             add_o,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_cin,
    input  logic [31:0]      add_fout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_flags,
    output logic [CNT_W-1:0] op_count
);

    fp_class_t   in_cls_a, in_cls_b;
    logic        s1_valid;
    logic        s1_op;
    logic [31:0] s1_a, s1_b;
    fp_class_t   s1_cls_a, s1_cls_b;

    logic        s2_en;
    logic        s1_load;
    logic        sb_eff;
    logic [31:0] res_d;
    logic [2:0]  flags_d;

    fp_classify u_cls_a (.value(in_a), .cls(in_cls_a));
    fp_classify u_cls_b (.value(in_b), .cls(in_cls_b));

    assign s2_en    = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_en;
    assign s1_load  = in_valid && in_ready;

    assign add_a   = s1_a;
    assign add_b   = s1_b;
    assign add_o   = s1_op;
    assign add_cin = 1'b0;

    // S1: operand register. Data only changes on a load so the adder inputs
    // hold their last value while S1 is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cls_a <= '0;
            s1_cls_b <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s1_load) begin
                s1_op    <= in_op;
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_cls_a <= in_cls_a;
                s1_cls_b <= in_cls_b;
            end
        end
    end

    // Special-case override; first matching branch wins.
    always_comb begin
        sb_eff  = s1_cls_b.sign ^ s1_op;
        res_d   = add_fout;
        flags_d = 3'b000;
        if (s1_cls_a.nan || s1_cls_b.nan) begin
            res_d           = QNAN;
            flags_d[F_NAN]  = 1'b1;
        end else if (s1_cls_a.inf && s1_cls_b.inf && (s1_cls_a.sign != sb_eff)) begin
            res_d           = QNAN;
            flags_d[F_NAN]  = 1'b1;
        end else if (s1_cls_a.inf) begin
            res_d           = {s1_cls_a.sign, EXP_MAX, 23'h0};
            flags_d[F_INF]  = 1'b1;
        end else if (s1_cls_b.inf) begin
            res_d           = {sb_eff, EXP_MAX, 23'h0};
            flags_d[F_INF]  = 1'b1;
        end else if (s1_cls_a.zero && s1_cls_b.zero) begin
            // -0 only when both effective signs are negative.
            res_d           = {s1_cls_a.sign & sb_eff, 31'h0};
            flags_d[F_ZERO] = 1'b1;
        end else if (s1_cls_a.zero) begin
            res_d           = {sb_eff, s1_b[30:0]};
        end else if (s1_cls_b.zero) begin
            res_d           = s1_a;
        end else if ((s1_a[30:0] == s1_b[30:0]) && (s1_cls_a.sign != sb_eff)) begin
            // Exact cancellation yields +0 in round-to-nearest.
            res_d           = 32'h0;
            flags_d[F_ZERO] = 1'b1;
        end else begin
            res_d = add_fout;
            if (add_fout[30:23] == EXP_MAX) begin
                flags_d[F_INF] = 1'b1;
            end else if (add_fout[30:23] == 8'h00) begin
                flags_d[F_ZERO] = 1'b1;
            end
        end
    end

    // S2: output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res_d;
                out_flags  <= flags_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fp_addsub_issue.sv
// ----------------------------------------------------------------------------
// tb_fp_addsub_issue
// Directed bench for fp_addsub_issue with a table-driven adder stand-in.
// ----------------------------------------------------------------------------
module tb_fp_addsub_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [31:0] in_a, in_b;
    logic        add_o;
    logic [31:0] add_a, add_b;
    logic        add_cin;
    logic [31:0] add_fout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
    logic [15:0] op_count;

    fp_addsub_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .add_o      (add_o),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_fout   (add_fout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .op_count   (op_count)
    );

    // ------------------------------------------------------------------ clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------- adder stand-in table
    // Hand-computed sums for every operand pair that reaches the adder path.
    function automatic logic [31:0] adder_model(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic o);
        logic [64:0] key;
        key = {o, a, b};
        case (key)
            {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2
            {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2
            {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000; // 3-1
            {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1
            {1'b1, 32'h40800000, 32'h3F800000}: return 32'h40400000; // 4-1
            {1'b1, 32'h40000000, 32'h3F800000}: return 32'h3F800000; // 2-1
            {1'b0, 32'h3FC00000, 32'h3FC00000}: return 32'h40400000; // 1.5+1.5
            {1'b0, 32'h40800000, 32'h40800000}: return 32'h41000000; // 4+4
            {1'b0, 32'h7F000000, 32'h7F000000}: return 32'h7F800000; // overflow
            {1'b1, 32'h00800001, 32'h00800000}: return 32'h00000001; // underflow
            default:                            return 32'hDEADBEEF;
        endcase
    endfunction

    always_comb add_fout = adder_model(add_a, add_b, add_o);

    // ------------------------------------------------------- check / report
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [34:0] got,
                             input logic [34:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    logic [34:0] exp_q[$];
    logic [34:0] mon_exp;
    int          sent_cnt = 0;
    int          acc_cnt  = 0;

    // Sample a little after each falling edge, once all bench drives settle.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("stale_out", {34'b0, out_valid}, 35'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_val("result", {out_flags, out_result}, mon_exp);
            end
        end
    end

    // --------------------------------------------------------------- driver
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] er,
                        input logic [2:0] ef);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check_val("send_timeout", 35'd0, 35'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back({ef, er});
        sent_cnt++;
        acc_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check_val("drain_timeout", 35'd0, 35'd1);
        @(negedge clk);
        #3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        sent_cnt = 0;
        acc_cnt  = 0;
    endtask

    // --------------------------------------------------------- vector tables
    localparam int NSP = 18;
    logic [31:0] sp_a[NSP], sp_b[NSP], sp_r[NSP];
    logic        sp_o[NSP];
    logic [2:0]  sp_f[NSP];

    localparam int NST = 8;
    logic [31:0] st_a[NST], st_b[NST], st_r[NST];
    logic        st_o[NST];

    task automatic set_sp(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic o, input logic [31:0] r, input logic [2:0] f);
        sp_a[i] = a; sp_b[i] = b; sp_o[i] = o; sp_r[i] = r; sp_f[i] = f;
    endtask

    task automatic set_st(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic o, input logic [31:0] r);
        st_a[i] = a; st_b[i] = b; st_o[i] = o; st_r[i] = r;
    endtask

    // ---------------------------------------------------------- watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------- main
    logic bp_done, st_done;

    initial begin
        set_sp(0,  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100); // inf-inf
        set_sp(1,  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100); // inf+-inf
        set_sp(2,  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b010); // inf+1
        set_sp(3,  32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b010); // 1-inf
        set_sp(4,  32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100); // nan a
        set_sp(5,  32'h3F800000, 32'hFF800001, 1'b1, 32'h7FC00000, 3'b100); // nan b
        set_sp(6,  32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 3'b001); // 3-3
        set_sp(7,  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b001); // -0+-0
        set_sp(8,  32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000); // 0-1
        set_sp(9,  32'h40000000, 32'h00000000, 1'b0, 32'h40000000, 3'b000); // 2+0
        set_sp(10, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 3'b001); // 0+0
        set_sp(11, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b001); // 0-0
        set_sp(12, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b001); // -0-0
        set_sp(13, 32'h00000005, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000); // den+1
        set_sp(14, 32'hC0400000, 32'h40400000, 1'b0, 32'h00000000, 3'b001); // -3+3
        set_sp(15, 32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 3'b010); // ovf
        set_sp(16, 32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 3'b001); // unf
        set_sp(17, 32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 3'b000); // 4-1

        set_st(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
        set_st(1, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000);
        set_st(2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000);
        set_st(3, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        set_st(4, 32'h40800000, 32'h3F800000, 1'b1, 32'h40400000);
        set_st(5, 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000);
        set_st(6, 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000);
        set_st(7, 32'h40800000, 32'h40800000, 1'b0, 32'h41000000);

        // ---- reset values
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        check_val("rst_out_valid", {34'b0, out_valid}, 35'd0);
        check_val("rst_out_result", {3'b0, out_result}, 35'd0);
        check_val("rst_out_flags", {32'b0, out_flags}, 35'd0);
        check_val("rst_op_count", {19'b0, op_count}, 35'd0);
        check_val("rst_add_a", {3'b0, add_a}, 35'd0);
        check_val("rst_add_b", {3'b0, add_b}, 35'd0);
        check_val("rst_add_o", {34'b0, add_o}, 35'd0);
        check_val("add_cin", {34'b0, add_cin}, 35'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_in_ready", {34'b0, in_ready}, 35'd1);

        // ---- normal add with exact 2-cycle latency
        out_ready = 1'b1;
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        #3;
        check_val("lat_1cyc_valid", {34'b0, out_valid}, 35'd0);
        @(negedge clk);
        #3;
        check_val("lat_2cyc_valid", {34'b0, out_valid}, 35'd1);
        check_val("add_result", {out_flags, out_result}, {3'b000, 32'h40400000});
        @(negedge clk);
        #3;
        check_val("add_op_count", {19'b0, op_count}, 35'd1);
        check_val("add_valid_drop", {34'b0, out_valid}, 35'd0);

        // ---- special cases, one after another
        for (int i = 0; i < NSP; i++) begin
            send(sp_a[i], sp_b[i], sp_o[i], sp_r[i], sp_f[i]);
        end
        drain();
        check_val("sp_op_count", {19'b0, op_count}, {19'b0, 16'(sent_cnt)});

        // ---- backpressure: two accepted, third held, stable output
        do_reset();
        out_ready = 1'b0;
        bp_done   = 1'b0;
        fork
            begin
                send(st_a[0], st_b[0], st_o[0], st_r[0], 3'b000);
                send(st_a[1], st_b[1], st_o[1], st_r[1], 3'b000);
                send(st_a[2], st_b[2], st_o[2], st_r[2], 3'b000);
                bp_done = 1'b1;
            end
        join_none
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #3;
            check_val("bp_valid", {34'b0, out_valid}, 35'd1);
            check_val("bp_hold", {out_flags, out_result}, {3'b000, 32'h40400000});
            check_val("bp_in_ready", {34'b0, in_ready}, 35'd0);
            @(negedge clk);
        end
        check_val("bp_accepted", 35'(acc_cnt), 35'd2);
        out_ready = 1'b1;
        for (int n = 0; n < 50 && !bp_done; n++) @(negedge clk);
        check_val("bp_sender_done", {34'b0, bp_done}, 35'd1);
        drain();
        check_val("bp_op_count", {19'b0, op_count}, 35'd3);

        // ---- reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        send(st_a[3], st_b[3], st_o[3], st_r[3], 3'b000);
        send(st_a[4], st_b[4], st_o[4], st_r[4], 3'b000);
        #3;
        check_val("full_stall", {34'b0, in_ready}, 35'd0);
        check_val("full_valid", {34'b0, out_valid}, 35'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", {34'b0, out_valid}, 35'd0);
        check_val("mid_rst_count", {19'b0, op_count}, 35'd0);
        exp_q.delete();
        sent_cnt = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check_val("mid_rst_in_ready", {34'b0, in_ready}, 35'd1);
        repeat (4) begin
            @(negedge clk);
            #3;
            check_val("no_stale_valid", {34'b0, out_valid}, 35'd0);
        end

        // ---- streaming: 8 in, 8 out, no bubbles
        st_done = 1'b0;
        fork
            begin
                for (int i = 0; i < NST; i++) begin
                    send(st_a[i], st_b[i], st_o[i], st_r[i], 3'b000);
                end
                st_done = 1'b1;
            end
        join_none
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(negedge clk);
            #3;
        end
        for (int i = 0; i < NST; i++) begin
            check_val("stream_valid", {34'b0, out_valid}, 35'd1);
            @(negedge clk);
            #3;
        end
        check_val("stream_end", {34'b0, out_valid}, 35'd0);
        check_val("stream_sender_done", {34'b0, st_done}, 35'd1);
        drain();
        check_val("stream_op_count", {19'b0, op_count}, 35'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
